// File: rtl/sobel_stream_core.sv
// sobel_stream_core: streaming 3x3 Sobel edge filter with valid/ready on both
// sides, zero borders and a clamped-magnitude / binary-threshold output mode.
// Optional build macro SOBEL_FRAME_CNT_EN adds a 16-bit completed-frame counter
// output frame_cnt_o.
//
// Handshake: a transfer happens on a rising edge where valid && ready. Once
// pix_valid_o is high, pix_o/pix_valid_o hold until pix_ready_i accepts them.
// Input is only taken when the output register can advance, so one stall
// freezes the whole pipeline.
module sobel_stream_core #(
    parameter int IMG_W = 540,
    parameter int IMG_H = 540,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [PIX_W-1:0] thresh_i,
    input  logic [PIX_W-1:0] pix_i,
    input  logic             pix_valid_i,
    output logic             pix_ready_o,
    output logic [PIX_W-1:0] pix_o,
    output logic             pix_valid_o,
    input  logic             pix_ready_i,
`ifdef SOBEL_FRAME_CNT_EN
    output logic [15:0]      frame_cnt_o,
`endif
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int CW = $clog2(IMG_W + 2);
    localparam int RW = $clog2(IMG_H);
    localparam int AW = $clog2(IMG_W);
    localparam int SW = PIX_W + 3;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] DRAIN_N  = CW'(IMG_W + 1);

    state_t state_q, state_d;

    logic [CW-1:0]    col_q, drain_q;
    logic [RW-1:0]    row_q;
    logic             mode_q;
    logic [PIX_W-1:0] thresh_q;
    logic [PIX_W-1:0] pix_o_q;
    logic             valid_q;
`ifdef SOBEL_FRAME_CNT_EN
    logic [15:0]      frame_cnt_q;
`endif

    // Line buffers (row r-1 in lb0, row r-2 in lb1) and the two older window columns.
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] w_t0_q, w_m0_q, w_b0_q, w_t1_q, w_m1_q, w_b1_q;
    logic [PIX_W-1:0] n_t, n_m, n_b;

    logic adv, in_acc, last_in, produce, interior;
    logic [AW-1:0] col_idx;

    logic [SW-1:0]        col_l, col_r, row_t, row_b, ax, ay, mag;
    logic signed [SW-1:0] gx, gy;
    logic [PIX_W-1:0]     res_pix;

    assign adv         = !valid_q || pix_ready_i;
    assign pix_ready_o = (state_q == S_RUN) && adv;
    assign in_acc      = pix_valid_i && pix_ready_o;
    assign last_in     = in_acc && (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign col_idx     = col_q[AW-1:0];
    assign pix_o       = pix_o_q;
    assign pix_valid_o = valid_q;
    assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o      = (state_q == S_DONE);
`ifdef SOBEL_FRAME_CNT_EN
    assign frame_cnt_o = frame_cnt_q;
`endif

    // The accept of input (r,c) completes the window centred on (r-1,c-1),
    // i.e. output linear index r*IMG_W+c-IMG_W-1; column 0 and row 1 map to borders.
    assign produce  = (row_q >= RW'(2)) || ((row_q == RW'(1)) && (col_q >= CW'(1)));
    assign interior = (row_q >= RW'(2)) && (col_q >= CW'(2));

    assign n_t = lb1[col_idx];
    assign n_m = lb0[col_idx];
    assign n_b = pix_i;

    // Sobel kernels over {old col 0, old col 1, incoming column}, then mode select.
    always_comb begin
        col_l = {3'b000, w_t0_q} + {2'b00, w_m0_q, 1'b0} + {3'b000, w_b0_q};
        col_r = {3'b000, n_t} + {2'b00, n_m, 1'b0} + {3'b000, n_b};
        row_t = {3'b000, w_t0_q} + {2'b00, w_t1_q, 1'b0} + {3'b000, n_t};
        row_b = {3'b000, w_b0_q} + {2'b00, w_b1_q, 1'b0} + {3'b000, n_b};
        gx    = $signed(col_r) - $signed(col_l);
        gy    = $signed(row_b) - $signed(row_t);
        ax    = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
        ay    = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag   = ax + ay;
        if (mode_q) begin
            res_pix = (mag >= {3'b000, thresh_q}) ? '1 : '0;
        end else begin
            res_pix = (|mag[SW-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
        end
        if (!interior) begin
            res_pix = '0;
        end
    end

    // Line-buffer RAM: deliberately not reset, the border mask hides stale data.
    always_ff @(posedge clk) begin
        if (in_acc) begin
            lb1[col_idx] <= lb0[col_idx];
            lb0[col_idx] <= pix_i;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (last_in) state_d = S_DRAIN;
            S_DRAIN: if (adv && (drain_q == DRAIN_N)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counters, captured configuration, window shift and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            drain_q  <= '0;
            mode_q   <= 1'b0;
            thresh_q <= '0;
            pix_o_q  <= '0;
            valid_q  <= 1'b0;
            w_t0_q   <= '0;
            w_m0_q   <= '0;
            w_b0_q   <= '0;
            w_t1_q   <= '0;
            w_m1_q   <= '0;
            w_b1_q   <= '0;
`ifdef SOBEL_FRAME_CNT_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (start_i) begin
                        col_q    <= '0;
                        row_q    <= '0;
                        drain_q  <= '0;
                        mode_q   <= mode_i;
                        thresh_q <= thresh_i;
                    end
                end
                S_RUN: begin
                    if (adv) begin
                        valid_q <= in_acc && produce;
                        if (in_acc && produce) pix_o_q <= res_pix;
                    end
                    if (in_acc) begin
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        w_t0_q <= w_t1_q;
                        w_m0_q <= w_m1_q;
                        w_b0_q <= w_b1_q;
                        w_t1_q <= n_t;
                        w_m1_q <= n_m;
                        w_b1_q <= n_b;
                    end
                end
                S_DRAIN: begin
                    if (adv) begin
                        if (drain_q != DRAIN_N) begin
                            valid_q <= 1'b1;
                            pix_o_q <= '0;
                            drain_q <= drain_q + 1'b1;
                        end else begin
                            valid_q <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    valid_q <= 1'b0;
`ifdef SOBEL_FRAME_CNT_EN
                    frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
                end
                default: valid_q <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_stream_core.sv
// Bench for sobel_stream_core on a 5x4 frame of 8-bit pixels. The driver pushes
// hand-computed expected outputs into exp_q; a negedge monitor pops and compares
// on every output handshake.
module tb_sobel_stream_core;
  localparam int W = 5;
  localparam int H = 4;
  localparam int P = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start_i = 1'b0;
  logic         mode_i = 1'b0;
  logic [P-1:0] thresh_i = '0;
  logic [P-1:0] pix_i = '0;
  logic         pix_valid_i = 1'b0;
  logic         pix_ready_o;
  logic [P-1:0] pix_o;
  logic         pix_valid_o;
  logic         pix_ready_i = 1'b1;
  logic         busy_o;
  logic         done_o;
`ifdef SOBEL_FRAME_CNT_EN
  logic [15:0]  frame_cnt;
`endif

  sobel_stream_core #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .thresh_i(thresh_i),
    .pix_i(pix_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .pix_o(pix_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
`ifdef SOBEL_FRAME_CNT_EN
    .frame_cnt_o(frame_cnt),
`endif
    .busy_o(busy_o), .done_o(done_o)
  );

  // scoreboard state
  logic [P-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int done_cnt = 0;
  int frames_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: compare every accepted output against the head of exp_q
  always @(negedge clk) begin
    if (!rst) begin
      if (done_o) done_cnt++;
      if (pix_valid_o && pix_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0d expected none", pix_o);
        end else begin
          chk("pix_o", 32'(pix_o), 32'(exp_q.pop_front()));
          last_hs_cyc = cyc;
        end
      end
    end
  end

  function automatic logic [P-1:0] pat(input int kind, input int c);
    case (kind)
      0:       return 8'd100;
      1:       return (c < 2) ? 8'd0 : 8'd40;
      default: return (c < 2) ? 8'd0 : 8'd255;
    endcase
  endfunction

  // expected frame: rows 0 and H-1 zero, rows 1..H-2 equal to mid_row {c0,...,c4}
  task automatic push_exp(input logic [39:0] mid_row);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back((r == 0 || r == H - 1) ? 8'd0 : mid_row[8*(W-1-c) +: 8]);
  endtask

  // driver tasks
  task automatic start_frame(input logic mode, input logic [P-1:0] th);
    @(posedge clk); #1;
    mode_i = mode; thresh_i = th; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_frame(input int kind, input int max_acc);
    int acc = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        bit got = 0;
        int guard = 0;
        if (acc == max_acc) begin
          pix_valid_i = 1'b0;
          return;
        end
        pix_i = pat(kind, c);
        pix_valid_i = 1'b1;
        while (!got) begin
          @(negedge clk);
          if (pix_ready_o) got = 1;
          else begin
            guard++;
            if (guard > 200) begin
              n_checks++; n_fail++;
              $display("FAIL input_timeout: got no ready expected ready within 200 cycles");
              pix_valid_i = 1'b0;
              return;
            end
          end
        end
        @(posedge clk); #1;
        acc++;
      end
    end
    pix_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1;
        chk("done_latency", 32'(cyc - last_hs_cyc), 32'd1);
        chk("busy_at_done", 32'(busy_o), 32'd0);
        chk("valid_at_done", 32'(pix_valid_o), 32'd0);
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done_o), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    if (seen) frames_done++;
`ifdef SOBEL_FRAME_CNT_EN
    chk("frame_cnt", 32'(frame_cnt), 32'(frames_done));
`endif
  endtask

  task automatic run_frame(input int kind, input logic mode, input logic [P-1:0] th,
                           input logic [39:0] mid_row);
    push_exp(mid_row);
    start_frame(mode, th);
    send_frame(kind, 1000);
    wait_done();
  endtask

  initial begin
    logic [P-1:0] p0;
    logic v0;
    int dc;
    #2 rst = 1'b1;
    #1;
    chk("rst_pix_o", 32'(pix_o), 32'd0);
    chk("rst_valid", 32'(pix_valid_o), 32'd0);
    chk("rst_ready", 32'(pix_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // constant frame, step frame (mode 0/1), threshold above magnitude, clamp
    run_frame(0, 1'b0, 8'd0,   {8'd0, 8'd0,   8'd0,   8'd0, 8'd0});
    run_frame(1, 1'b0, 8'd0,   {8'd0, 8'd160, 8'd160, 8'd0, 8'd0});
    run_frame(1, 1'b1, 8'd100, {8'd0, 8'd255, 8'd255, 8'd0, 8'd0});
    run_frame(1, 1'b1, 8'd161, {8'd0, 8'd0,   8'd0,   8'd0, 8'd0});
    run_frame(2, 1'b0, 8'd0,   {8'd0, 8'd255, 8'd255, 8'd0, 8'd0});

    // backpressure: downstream stalls for 10 cycles mid-frame
    fork
      run_frame(1, 1'b0, 8'd0, {8'd0, 8'd160, 8'd160, 8'd0, 8'd0});
      begin
        repeat (12) @(posedge clk);
        #1 pix_ready_i = 1'b0;
        @(negedge clk);
        v0 = pix_valid_o;
        p0 = pix_o;
        chk("stall_valid_high", 32'(v0), 32'd1);
        repeat (10) begin
          @(negedge clk);
          chk("stall_valid_stable", 32'(pix_valid_o), 32'(v0));
          chk("stall_pix_stable", 32'(pix_o), 32'(p0));
          chk("stall_ready_low", 32'(pix_ready_o), 32'd0);
        end
        @(posedge clk);
        #1 pix_ready_i = 1'b1;
      end
    join

    // reset mid-frame after 7 accepts, then a clean frame
    push_exp({8'd0, 8'd160, 8'd160, 8'd0, 8'd0});
    start_frame(1'b0, 8'd0);
    send_frame(1, 7);
    dc = done_cnt;
    rst = 1'b1;
    #1;
    chk("midrst_pix_o", 32'(pix_o), 32'd0);
    chk("midrst_valid", 32'(pix_valid_o), 32'd0);
    chk("midrst_ready", 32'(pix_ready_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
`ifdef SOBEL_FRAME_CNT_EN
    frames_done = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt), 32'(dc));
    run_frame(1, 1'b0, 8'd0, {8'd0, 8'd160, 8'd160, 8'd0, 8'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
